// File: rtl/traffic_junction_ctrl.sv
// Two-road junction sequencer: main road rests on green, side-road and
// pedestrian demand are latched and served in a fixed phase order.
// All lamp outputs are a Moore decode of the phase register.
module traffic_junction_ctrl #(
   parameter int unsigned GREEN_MIN = 8,
   parameter int unsigned GREEN_MAX = 20,
   parameter int unsigned YELLOW_T  = 3,
   parameter int unsigned ALLRED_T  = 1,
   parameter int unsigned WALK_T    = 6,
   parameter int unsigned CW        = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       side_req,
   input  logic       ped_req,
   output logic       main_red,
   output logic       main_yellow,
   output logic       main_green,
   output logic       side_red,
   output logic       side_yellow,
   output logic       side_green,
   output logic       walk,
   output logic [2:0] phase,
   output logic       ped_pend
);

   localparam logic [2:0] MAIN_G = 3'd0;
   localparam logic [2:0] MAIN_Y = 3'd1;
   localparam logic [2:0] RED_A  = 3'd2;
   localparam logic [2:0] WALK   = 3'd3;
   localparam logic [2:0] SIDE_G = 3'd4;
   localparam logic [2:0] SIDE_Y = 3'd5;
   localparam logic [2:0] RED_B  = 3'd6;

   // Terminal timer values: a phase of length N leaves when tmr == N-1.
   localparam logic [CW-1:0] GMIN_L = CW'(GREEN_MIN - 1);
   localparam logic [CW-1:0] GMAX_L = CW'(GREEN_MAX - 1);
   localparam logic [CW-1:0] YEL_L  = CW'(YELLOW_T - 1);
   localparam logic [CW-1:0] ARED_L = CW'(ALLRED_T - 1);
   localparam logic [CW-1:0] WALK_L = CW'(WALK_T - 1);

   logic [2:0]    phase_q;
   logic [2:0]    phase_nxt;
   logic [CW-1:0] tmr;
   logic          side_pend;
   logic          ped_pend_q;
   logic          sp;
   logic          pp;

   assign sp = side_pend | side_req;
   assign pp = ped_pend_q | ped_req;

   // Next-phase selection from current phase, timer and demand.
   always_comb begin
      phase_nxt = phase_q;
      case (phase_q)
         MAIN_G: if (tmr >= GMIN_L && (sp || pp)) phase_nxt = MAIN_Y;
         MAIN_Y: if (tmr == YEL_L) phase_nxt = RED_A;
         RED_A:  if (tmr == ARED_L) phase_nxt = pp ? WALK : SIDE_G;
         // With no side demand the walk returns straight to main green;
         // RED_B is only reached through SIDE_Y.
         WALK:   if (tmr == WALK_L) phase_nxt = sp ? SIDE_G : MAIN_G;
         SIDE_G: if (tmr == GMAX_L || (tmr >= GMIN_L && !side_req))
                    phase_nxt = SIDE_Y;
         SIDE_Y: if (tmr == YEL_L) phase_nxt = RED_B;
         RED_B:  if (tmr == ARED_L) phase_nxt = MAIN_G;
         default: phase_nxt = MAIN_G;
      endcase
   end

   // Phase register and phase timer (clears on change, else saturating count).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= MAIN_G;
         tmr     <= '0;
      end else begin
         phase_q <= phase_nxt;
         if (phase_nxt != phase_q)
            tmr <= '0;
         else if (tmr != '1)
            tmr <= tmr + CW'(1);
      end
   end

   // Demand latches: cleared on entry to the serving phase, not set while served.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         side_pend  <= 1'b0;
         ped_pend_q <= 1'b0;
      end else begin
         if (phase_nxt == SIDE_G)
            side_pend <= 1'b0;
         else if (side_req && phase_q != SIDE_G)
            side_pend <= 1'b1;

         if (phase_nxt == WALK)
            ped_pend_q <= 1'b0;
         else if (ped_req && phase_q != WALK)
            ped_pend_q <= 1'b1;
      end
   end

   // Moore lamp decode: exactly one lamp per road.
   always_comb begin
      main_green  = (phase_q == MAIN_G);
      main_yellow = (phase_q == MAIN_Y);
      main_red    = !(main_green || main_yellow);
      side_green  = (phase_q == SIDE_G);
      side_yellow = (phase_q == SIDE_Y);
      side_red    = !(side_green || side_yellow);
      walk        = (phase_q == WALK);
   end

   assign phase    = phase_q;
   assign ped_pend = ped_pend_q;

endmodule
